// File: rtl/rib_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rib_arbiter
// Brief    : Single-outstanding three-master bus arbiter (debug, LSU, fetch)
//            with fetch starvation protection and pipeline hold flag.
// Revision : 1.0 - initial release
// ============================================================================
module rib_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            m_req_i,
    input  logic [3*ADDR_W-1:0]   m_addr_i,
    input  logic [3*DATA_W-1:0]   m_wdata_i,
    input  logic [2:0]            m_we_i,
    input  logic [11:0]           m_be_i,
    output logic [2:0]            m_gnt_o,
    output logic [2:0]            m_rvalid_o,
    output logic [DATA_W-1:0]     m_rdata_o,
    output logic                  s_req_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    input  logic                  s_gnt_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_W-1:0]     s_rdata_i,
    output logic [2:0]            hold_flag_o
);

    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);
    localparam logic [2:0] c_pipe_flow    = 3'b000;
    localparam logic [2:0] c_pipe_pause   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_owner;
    logic [1:0]          w_winner;
    logic [2:0]          w_owner_oh;
    logic [7:0]          r_starve_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [3:0]          r_be;
    logic                w_arb;
    logic                w_starved;
    logic                w_m2_busy;

    assign w_arb      = (r_state == ST_IDLE) && (|m_req_i);
    assign w_starved  = m_req_i[2] && (r_starve_cnt == c_starve_limit);
    assign w_m2_busy  = (r_state != ST_IDLE) && (r_owner == 2'd2);
    assign w_owner_oh = 3'b001 << r_owner;

    // Fixed priority m0 > m1 > m2, except a starved fetch overtakes the LSU.
    always_comb begin
        w_winner = 2'd2;
        if (m_req_i[0]) begin
            w_winner = 2'd0;
        end else if (w_starved) begin
            w_winner = 2'd2;
        end else if (m_req_i[1]) begin
            w_winner = 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= 2'd0;
            r_starve_cnt <= 8'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_be         <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) begin
                r_owner <= w_winner;
                r_addr  <= m_addr_i[int'(w_winner)*ADDR_W +: ADDR_W];
                r_wdata <= m_wdata_i[int'(w_winner)*DATA_W +: DATA_W];
                r_we    <= m_we_i[w_winner];
                r_be    <= m_be_i[int'(w_winner)*4 +: 4];
            end
            // Selection of m2 wins over the increment in the same cycle.
            if (w_arb && (w_winner == 2'd2)) begin
                r_starve_cnt <= 8'd0;
            end else if (m_req_i[2] && !w_m2_busy &&
                         (r_starve_cnt != c_starve_limit)) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_gnt_o     = 3'b000;
        m_rvalid_o  = 3'b000;
        s_req_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|m_req_i) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                s_req_o = 1'b1;
                if (s_gnt_i) begin
                    m_gnt_o     = w_owner_oh;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_rvalid_i) begin
                    m_rvalid_o  = w_owner_oh;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;
    assign s_we_o    = r_we;
    assign s_be_o    = r_be;
    assign m_rdata_o = s_rdata_i;

    // Fetch is released in the cycle its own response returns.
    assign hold_flag_o = (m_req_i[2] && !rst_i &&
                          !((r_state == ST_RESP) && (r_owner == 2'd2) && s_rvalid_i))
                         ? c_pipe_pause : c_pipe_flow;

endmodule
`default_nettype wire

// File: tb/tb_rib_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rib_arbiter
// Brief    : Directed and randomized self-checking bench for rib_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rib_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int L  = 8;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [2:0]      m_req_i;
    logic [3*AW-1:0] m_addr_i;
    logic [3*DW-1:0] m_wdata_i;
    logic [2:0]      m_we_i;
    logic [11:0]     m_be_i;
    logic [2:0]      m_gnt_o;
    logic [2:0]      m_rvalid_o;
    logic [DW-1:0]   m_rdata_o;
    logic            s_req_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_wdata_o;
    logic            s_we_o;
    logic [3:0]      s_be_o;
    logic            s_gnt_i;
    logic            s_rvalid_i;
    logic [DW-1:0]   s_rdata_i;
    logic [2:0]      hold_flag_o;

    always #5 clk = ~clk;

    rib_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(L)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .hold_flag_o(hold_flag_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one transaction in flight, "accepted" once the slave granted.
    bit          busy, acc;
    int          own, cnt;
    logic [31:0] la, lwd;
    logic        lwe;
    logic [3:0]  lbe;

    logic [2:0]  e_gnt_q, e_rv_q;
    logic [2:0]  gnt_log[$];
    logic [31:0] addr_log[$];
    logic [31:0] rdata_log[$];
    int          n_sreq, n_gnt, n_rv, n_hold;
    int          gcnt, rcnt;
    bit          keep[3];
    bit          rnd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        busy = 0; acc = 0; own = 0; cnt = 0;
        la = '0; lwd = '0; lwe = 1'b0; lbe = '0;
    endtask

    function automatic int pick(input logic [2:0] req, input int c);
        if (req[0])                 return 0;
        if (req[2] && c == L)       return 2;
        if (req[1])                 return 1;
        return 2;
    endfunction

    task automatic clear_logs();
        gnt_log.delete(); addr_log.delete(); rdata_log.delete();
        n_sreq = 0; n_gnt = 0; n_rv = 0; n_hold = 0;
    endtask

    task automatic check_outputs();
        logic [2:0]  eg, ev, eh;
        logic        es;
        logic [31:0] ea, ew;
        logic        ewe;
        logic [3:0]  ebe;
        eg = 3'b000; ev = 3'b000; eh = 3'b000; es = 1'b0;
        ea = la; ew = lwd; ewe = lwe; ebe = lbe;
        if (rst_i) begin
            ea = '0; ew = '0; ewe = 1'b0; ebe = '0;
        end else begin
            es = busy && !acc;
            if (busy && !acc && s_gnt_i)   eg[own] = 1'b1;
            if (busy && acc && s_rvalid_i) ev[own] = 1'b1;
            if (m_req_i[2] && !(busy && acc && own == 2 && s_rvalid_i)) eh = 3'b001;
        end
        chk("s_req", s_req_o, es);
        chk("m_gnt", m_gnt_o, eg);
        chk("m_rvalid", m_rvalid_o, ev);
        chk("hold_flag", hold_flag_o, eh);
        chk("m_rdata", m_rdata_o, s_rdata_i);
        if (es || rst_i) begin
            chk("s_addr", s_addr_o, ea);
            chk("s_wdata", s_wdata_o, ew);
            chk("s_we", s_we_o, ewe);
            chk("s_be", s_be_o, ebe);
        end
        e_gnt_q = eg;
        e_rv_q  = ev;
        if (m_gnt_o != 3'b000) begin
            gnt_log.push_back(m_gnt_o);
            addr_log.push_back(s_addr_o);
            n_gnt++;
        end
        if (m_rvalid_o != 3'b000) begin
            rdata_log.push_back(m_rdata_o);
            n_rv++;
        end
        if (s_req_o) n_sreq++;
        if (hold_flag_o == 3'b001) n_hold++;
    endtask

    task automatic mstep();
        int  w;
        bit  pre_busy;
        int  pre_own;
        pre_busy = busy;
        pre_own  = own;
        w = pick(m_req_i, cnt);
        if (!busy) begin
            if (m_req_i != 3'b000) begin
                busy = 1; acc = 0; own = w;
                la  = m_addr_i[w*AW +: AW];
                lwd = m_wdata_i[w*DW +: DW];
                lwe = m_we_i[w];
                lbe = m_be_i[w*4 +: 4];
            end
        end else if (!acc) begin
            if (s_gnt_i) acc = 1;
        end else if (s_rvalid_i) begin
            busy = 0;
        end
        if (!pre_busy && m_req_i != 3'b000 && w == 2)
            cnt = 0;
        else if (m_req_i[2] && !(pre_busy && pre_own == 2))
            cnt = (cnt + 1 > L) ? L : cnt + 1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_i) mreset(); else mstep();
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [3:0] be);
        m_req_i[i]           = 1'b1;
        m_addr_i[i*AW +: AW] = a;
        m_wdata_i[i*DW +: DW] = d;
        m_we_i[i]            = we;
        m_be_i[i*4 +: 4]     = be;
    endtask

    // gw/rw < 0 selects random wait states; noise injects ignorable strobes.
    task automatic step(input int gw, input int rw, input bit noise);
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = $urandom;
        if (busy && !acc) begin
            s_gnt_i = (gw < 0) ? ($urandom_range(0, 2) == 0) : (gcnt >= gw);
            gcnt++;
            if (noise) s_rvalid_i = 1'($urandom_range(0, 1));
        end else if (busy && acc) begin
            s_rvalid_i = (rw < 0) ? ($urandom_range(0, 2) == 0) : (rcnt >= rw);
            rcnt++;
            if (noise) s_gnt_i = 1'($urandom_range(0, 1));
        end else if (noise) begin
            s_gnt_i = 1'($urandom_range(0, 1));
            s_rvalid_i = 1'($urandom_range(0, 1));
        end
        cycle();
        if (e_gnt_q != 3'b000) gcnt = 0;
        if (e_rv_q != 3'b000)  rcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (e_gnt_q[i]) begin
                if (rnd ? ($urandom_range(0, 1) == 1) : keep[i]) begin
                    m_addr_i[i*AW +: AW] = m_addr_i[i*AW +: AW] + 32'h100;
                    m_wdata_i[i*DW +: DW] = $urandom;
                    if (rnd) m_we_i[i] = 1'($urandom_range(0, 1));
                end else begin
                    m_req_i[i] = 1'b0;
                end
            end else if (rnd && !m_req_i[i] && $urandom_range(0, 3) == 0) begin
                set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
            end
        end
    endtask

    task automatic run_grants(input int n, input int gw, input int rw, input string tag);
        int k;
        k = 0;
        while (gnt_log.size() < n && k < 200) begin
            step(gw, rw, 1'b0);
            k++;
        end
        n_cmp++;
        assert (gnt_log.size() >= n) else begin
            n_err++;
            $error("FAIL %s: observed %0d grants expected %0d", tag, gnt_log.size(), n);
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        keep[0] = 0; keep[1] = 0; keep[2] = 0;
        while ((busy || m_req_i != 3'b000) && k < 200) begin
            step(0, 0, 1'b0);
            k++;
        end
        n_cmp++;
        assert (k < 200) else begin
            n_err++;
            $error("FAIL %s: observed %0d cycles without drain expected < 200", tag, k);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        m_req_i = '0; m_addr_i = '0; m_wdata_i = '0; m_we_i = '0; m_be_i = '0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        keep[0] = 0; keep[1] = 0; keep[2] = 0; rnd = 0;
        gcnt = 0; rcnt = 0;
        mreset();
        clear_logs();
        #1 rst_i = 1'b1;
        cycle();
        cycle();
        rst_i = 1'b0;

        // Single fetch read, fetch keeps requesting until its response.
        clear_logs();
        set_req(2, 32'h0000_0040, 32'h0, 1'b0, 4'hF);
        cycle();
        s_gnt_i = 1'b1;
        cycle();
        s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
        cycle();
        m_req_i[2] = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        cycle();
        chk("if_gnt", gnt_log[0], 3'b100);
        chk("if_addr", addr_log[0], 32'h0000_0040);
        chk("if_sreq_cycles", n_sreq, 1);
        chk("if_rdata", rdata_log[0], 32'h1234_5678);
        chk("if_hold_cycles", n_hold, 2);

        // Simultaneous requests resolve in priority order.
        clear_logs();
        set_req(0, 32'hA000_0000, 32'h1, 1'b1, 4'hF);
        set_req(1, 32'hA000_0010, 32'h2, 1'b0, 4'h1);
        set_req(2, 32'hA000_0020, 32'h3, 1'b0, 4'hF);
        run_grants(3, 1, 0, "prio");
        chk("prio_g0", gnt_log[0], 3'b001);
        chk("prio_g1", gnt_log[1], 3'b010);
        chk("prio_g2", gnt_log[2], 3'b100);
        chk("prio_a0", addr_log[0], 32'hA000_0000);
        chk("prio_a1", addr_log[1], 32'hA000_0010);
        chk("prio_a2", addr_log[2], 32'hA000_0020);
        drain("prio_drain");

        // Continuous LSU traffic: fetch gets in once the counter saturates.
        clear_logs();
        keep[1] = 1; keep[2] = 1;
        set_req(1, 32'hB000_0000, 32'h0, 1'b0, 4'hF);
        set_req(2, 32'hC000_0000, 32'h0, 1'b0, 4'hF);
        run_grants(5, 0, 0, "starve");
        chk("starve_g0", gnt_log[0], 3'b010);
        chk("starve_g1", gnt_log[1], 3'b010);
        chk("starve_g2", gnt_log[2], 3'b010);
        chk("starve_g3", gnt_log[3], 3'b100);
        chk("starve_g4", gnt_log[4], 3'b010);
        drain("starve_drain");

        // LSU write with slave wait states.
        clear_logs();
        set_req(1, 32'h1000_0004, 32'hAAAA_5555, 1'b1, 4'b0011);
        run_grants(1, 3, 2, "wait");
        drain("wait_drain");
        chk("wait_addr", addr_log[0], 32'h1000_0004);
        chk("wait_sreq_cycles", n_sreq, 4);
        chk("wait_gnt_cycles", n_gnt, 1);
        chk("wait_rv_cycles", n_rv, 1);

        // Debug master changes its address right after grant.
        clear_logs();
        keep[0] = 1;
        set_req(0, 32'h2000_0000, 32'h5, 1'b0, 4'hF);
        run_grants(1, 1, 1, "latch1");
        keep[0] = 0;
        run_grants(2, 1, 1, "latch2");
        chk("latch_a0", addr_log[0], 32'h2000_0000);
        chk("latch_a1", addr_log[1], 32'h2000_0100);
        drain("latch_drain");

        // Reset in the middle of a response phase.
        clear_logs();
        set_req(1, 32'h3000_0000, 32'h0, 1'b0, 4'hF);
        begin
            int k;
            k = 0;
            while (!(busy && acc) && k < 20) begin
                step(0, 100, 1'b0);
                k++;
            end
            n_cmp++;
            assert (k < 20) else begin
                n_err++;
                $error("FAIL rst_reach_resp: observed %0d cycles expected < 20", k);
            end
        end
        rst_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = '0;
        #1;
        check_outputs();
        chk("rst_rvalid", m_rvalid_o, 3'b000);
        chk("rst_hold", hold_flag_o, 3'b000);
        chk("rst_sreq", s_req_o, 1'b0);
        chk("rst_addr", s_addr_o, 32'h0);
        cycle();
        rst_i = 1'b0;
        gcnt = 0; rcnt = 0;
        cycle();
        cycle();
        s_rvalid_i = 1'b0;
        chk("rst_no_rvalid", n_rv, 0);

        // Randomized traffic with noisy slave strobes.
        rnd = 1;
        for (int i = 0; i < 1500; i++) step(-1, -1, 1'b1);
        rnd = 0;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Single-outstanding bus arbiter that shares the one system bus (ROM/RAM/peripherals) between three masters: debug/JTAG (m0), load-store unit (m1) and instruction fetch (m2).
- Sits between the core/debug module and the slave interconnect.
- Produces the pipeline hold flag so the fetch stage stalls while another master owns the bus.
- Includes starvation protection so fetch cannot be locked out indefinitely by back-to-back LSU traffic.

Parameters:
AddrW, 32, address width (MemAddrBus)
DataW, 32, data width (MemBus)
StarveLimit, 8, consecutive denied cycles after which m2 outranks m1 (range 1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
m_req_i  in  3  per-master request, bit index = master id
m_addr_i  in  3xAddrW  per-master address
m_wdata_i  in  3xDataW  per-master write data
m_we_i  in  3  per-master write enable
m_be_i  in  3x4  per-master byte enables
m_gnt_o  out  3  per-master grant, one-hot or zero
m_rvalid_o  out  3  per-master response valid, one-hot or zero
m_rdata_o  out  DataW  response data, broadcast to all masters
s_req_o  out  1  slave request
s_addr_o  out  AddrW  slave address
s_wdata_o  out  DataW  slave write data
s_we_o  out  1  slave write enable
s_be_o  out  4  slave byte enables
s_gnt_i  in  1  slave accepted request
s_rvalid_i  in  1  slave response valid (reads and writes)
s_rdata_i  in  DataW  slave read data
hold_flag_o  out  3  Pipe_Flow (3'b000) or Pipe_Pause (3'b001)

Behaviour:
- Clock is clk_i. Reset is rst_i, asynchronous and active-high.
- Reset values:
  - state = IDLE, owner = 0, starve_cnt = 0.
  - Latched request fields = 0.
  - All outputs = 0; hold_flag_o = Pipe_Flow.
- State machine has three states: IDLE, GRANT, RESP.
- IDLE:
  - If any m_req_i bit is set, select a winner, latch the winner id as owner, latch its addr/wdata/we/be, and go to GRANT.
  - If no request, stay in IDLE.
- Winner selection:
  - m0 has the highest priority.
  - Then m1, then m2.
  - Exception: if starve_cnt == StarveLimit and m2 is requesting, m2 beats m1. m0 still wins.
- GRANT:
  - s_req_o = 1; s_addr_o, s_wdata_o, s_we_o and s_be_o are driven from the latched fields.
  - When s_gnt_i = 1: m_gnt_o[owner] = 1 combinationally in the same cycle, then go to RESP.
  - Otherwise stay in GRANT.
- RESP:
  - s_req_o = 0.
  - When s_rvalid_i = 1: m_rvalid_o[owner] = 1 combinationally, then go to IDLE.
  - m_rdata_o = s_rdata_i at all times.
- Latency:
  - Arbitration takes one cycle: a request seen in IDLE at cycle t drives s_req_o at t+1.
  - Minimum transaction is 3 cycles (IDLE, GRANT with immediate s_gnt_i, RESP with immediate s_rvalid_i).
  - There is no back-to-back bypass; IDLE always lasts at least one cycle.
- Masters hold req and payload until their gnt. After gnt, a master may drop or change req; the arbiter uses only the latched values.
- A master whose req is withdrawn before grant simply loses arbitration. A transaction already in GRANT or RESP is never aborted.
- starve_cnt:
  - Increments each cycle m_req_i[2] = 1 and m2 is not the owner of a GRANT/RESP in progress.
  - Saturates at StarveLimit.
  - Clears to 0 in the cycle m2 is selected in IDLE.
  - Holds when m_req_i[2] = 0.
- hold_flag_o:
  - Pipe_Pause when m_req_i[2] = 1 and not (state == RESP, owner == 2, s_rvalid_i == 1).
  - Otherwise Pipe_Flow.
  - Combinational.
- Simultaneous events: s_gnt_i and s_rvalid_i asserted in the same GRANT cycle are treated as gnt only. The slave is required to respond no earlier than the cycle after gnt.
- s_rvalid_i in IDLE or GRANT and s_gnt_i in IDLE or RESP are ignored.
- Reset asserted mid-transaction forces IDLE immediately. Outputs go to their reset values asynchronously, with no pending gnt or rvalid delivered.

Test Plan:
- Single IF read: m_req_i = 3'b100, addr 0x0000_0040; slave gnt at first GRANT cycle, rvalid next cycle with 0x1234_5678. Required: s_req_o high 1 cycle; m_gnt_o = 3'b100 then m_rvalid_o = 3'b100 with m_rdata_o = 0x1234_5678; hold_flag_o = 3'b001 until the rvalid cycle.
- Priority: all three request in the same cycle. Required grant order m0, m1, m2. Each s_addr_o equals the respective master's address. Only one s_req_o burst at a time.
- Starvation: m1 requests continuously and m2 requests continuously, StarveLimit = 8, zero-wait slave. Required: after starve_cnt reaches 8, the next arbitration selects m2; starve_cnt returns to 0; m1 resumes afterwards.
- Slave wait states: m1 write, addr 0x1000_0004, be 4'b0011, wdata 0xAAAA_5555; s_gnt_i delayed 3 cycles and s_rvalid_i delayed 2 more. Required: s_* stable over all 4 GRANT cycles; m_gnt_o[1] only in the gnt cycle; m_rvalid_o[1] only in the rvalid cycle.
- Payload latch: m0 changes m_addr_i after m_gnt_o[0]. Required: the in-flight transaction is unaffected, and the new address appears only in the next GRANT phase.
- Reset mid-RESP: assert rst_i during RESP. Required: all outputs 0 and hold_flag_o = 3'b000 immediately; a subsequent s_rvalid_i after reset release produces no m_rvalid_o.
